// File: rtl/conv_operand_loader_pkg.sv
// Shared types and geometry for the convolution operand loader.
package conv_loader_pkg;
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_IN      = 16;
  localparam int N_FLT     = 9;
  localparam int FRAME_LEN = N_IN + N_FLT;
  localparam int CNT_W     = 5;
  localparam int RUN_W     = 5;
endpackage

// File: rtl/conv_operand_loader_if.sv
// Byte-stream handshake into the loader. Build with LOADER_FILTER_REUSE_EN to add flt_keep.
interface conv_operand_loader_if #(parameter int DATA_W = 8);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
`ifdef LOADER_FILTER_REUSE_EN
  logic              flt_keep;
`endif

  modport master (
`ifdef LOADER_FILTER_REUSE_EN
    output flt_keep,
`endif
    output s_valid, s_data, s_last,
    input  s_ready
  );

  modport slave (
`ifdef LOADER_FILTER_REUSE_EN
    input  flt_keep,
`endif
    input  s_valid, s_data, s_last,
    output s_ready
  );
endinterface

// File: rtl/conv_operand_loader_run_timer.sv
// Compute-window timer: load arms RUN_CYC cycles, expire flags the last one.
module loader_run_timer
  import conv_loader_pkg::*;
#(
  parameter int RUN_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  logic [RUN_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt_q <= '0;
    else if (load)                cnt_q <= RUN_W'(RUN_CYC - 1);
    else if (en && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign expire = en && (cnt_q == '0);
endmodule

// File: rtl/conv_operand_loader.sv
// Assembles a byte stream into 4x4 input / 3x3 filter operands and sequences the array's
// reset and result strobe. LOADER_FILTER_REUSE_EN adds input-only frames that keep the filter.
module conv_operand_loader
  import conv_loader_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RUN_CYC = 20
) (
  input  logic                      clk_in,
  input  logic                      rst,
  conv_operand_loader_if.slave      s,
  output logic [N_IN*DATA_W-1:0]    in_mat,
  output logic [N_FLT*DATA_W-1:0]   flt_mat,
  output logic                      array_rst,
  output logic                      busy,
  output logic                      res_strobe,
  output logic                      frame_err
);
  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              beat_cnt, last_cnt;
  logic [N_IN-1:0][DATA_W-1:0]   in_q;
  logic [N_FLT-1:0][DATA_W-1:0]  flt_q;
  logic accept, is_final, end_ok, bad, run_load, run_en, run_exp;

  assign s.s_ready = (state_q == LOAD) && !rst;
  assign accept    = s.s_valid && s.s_ready;

`ifdef LOADER_FILTER_REUSE_EN
  logic keep_q, keep_cur, flt_loaded;
  // flt_keep is only meaningful on the first beat; later beats use the latched copy
  assign keep_cur = (beat_cnt == '0) ? s.flt_keep : keep_q;
  assign last_cnt = keep_cur ? CNT_W'(N_IN - 1) : CNT_W'(FRAME_LEN - 1);
`else
  assign last_cnt = CNT_W'(FRAME_LEN - 1);
`endif

  assign is_final = (beat_cnt == last_cnt);
  assign end_ok   = accept && s.s_last && is_final;
  assign bad      = accept && (s.s_last != is_final);
  assign run_en   = (state_q == RUN);

  loader_run_timer #(.RUN_CYC(RUN_CYC)) u_timer (
    .clk    (clk_in),
    .rst    (rst),
    .load   (run_load),
    .en     (run_en),
    .expire (run_exp)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    array_rst  = 1'b1;
    busy       = 1'b0;
    res_strobe = 1'b0;
    run_load   = 1'b0;
    case (state_q)
      LOAD: if (end_ok) begin
        state_d  = RUN;
        run_load = 1'b1;
      end
      RUN: begin
        array_rst = 1'b0;
        busy      = 1'b1;
        if (run_exp) state_d = DONE;
      end
      DONE: begin
        array_rst  = 1'b0;
        busy       = 1'b1;
        res_strobe = 1'b1;
        state_d    = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // N_IN is 16, so bit 4 selects the bank and bits [3:0] are the element index in either
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      in_q      <= '0;
      flt_q     <= '0;
      frame_err <= 1'b0;
`ifdef LOADER_FILTER_REUSE_EN
      keep_q     <= 1'b0;
      flt_loaded <= 1'b0;
`endif
    end else if (accept) begin
      if (!beat_cnt[4]) in_q[beat_cnt[3:0]]  <= s.s_data;
      else              flt_q[beat_cnt[3:0]] <= s.s_data;
      beat_cnt <= (end_ok || bad) ? '0 : beat_cnt + 1'b1;
      if (bad) frame_err <= 1'b1;
`ifdef LOADER_FILTER_REUSE_EN
      if (beat_cnt == '0) keep_q <= s.flt_keep;
      if (end_ok && !keep_cur) flt_loaded <= 1'b1;
      if (end_ok && keep_cur && !flt_loaded) flt_q <= '0;
`endif
    end
  end

  assign in_mat  = in_q;
  assign flt_mat = flt_q;
endmodule

// File: doc/conv_operand_loader.md
Name: conv_operand_loader

Overview:
- Write-side front end for the 2x2 convolution systolic array (4x4 input, 3x3 filter, 2x2 output).
- Accepts a byte stream over a valid/ready handshake and assembles it into the parallel input and filter operand buses.
- Holds the array in reset while loading, releases it for a fixed compute window, then strobes downstream to sample the 2x2 result.
- The array itself is unchanged; this block owns its operands and its reset.

Parameters:
- DATA_W, 8: element width in bits.
- N_IN, 16: input-matrix beats per frame (4x4).
- N_FLT, 9: filter-matrix beats per frame (3x3).
- RUN_CYC, 20: cycles the array runs after reset release, before the results are sampled.

Ports:
- clk_in, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- s_valid, input, 1: stream beat valid.
- s_data, input, DATA_W: stream beat payload.
- s_last, input, 1: marks the final beat of a frame.
- s_ready, output, 1: loader accepts a beat this cycle.
- in_mat, output, N_IN*DATA_W: element i_rc at bits [DATA_W*(4r+c) +: DATA_W].
- flt_mat, output, N_FLT*DATA_W: element f_rc at bits [DATA_W*(3r+c) +: DATA_W].
- array_rst, output, 1: reset to the systolic array.
- busy, output, 1: high in RUN and DONE.
- res_strobe, output, 1: one-cycle pulse; downstream samples the array outputs this cycle.
- frame_err, output, 1: sticky framing-error flag.

Behaviour:
- Reset values: state=LOAD, beat_cnt=0, run_cnt=0, in_mat=0, flt_mat=0, array_rst=1, s_ready=0 during reset, res_strobe=0, busy=0, frame_err=0.
- Clock and reset are fixed: one clock clk_in; rst is asynchronous and active-high.
- A beat is accepted when s_valid && s_ready on a rising clk_in edge.
- s_ready is combinational and equals (state==LOAD). It does not depend on s_valid.
- LOAD state:
  - array_rst=1.
  - beat k (0..15) writes in_mat element k; beat k (16..24) writes flt_mat element k-16.
  - beat_cnt is 5 bits and increments per accepted beat.
  - Accepted beat with s_last=1 and beat_cnt==N_IN+N_FLT-1: wrap beat_cnt to 0, go to RUN, run_cnt=0.
  - Framing error: s_last=1 at any other count, or s_last=0 at the final count. Set frame_err, reset beat_cnt to 0, stay in LOAD. The erroneous beat's data is still written. The next beat starts a fresh frame.
  - Partially written operand registers are not cleared; they are overwritten on reload.
- RUN state:
  - array_rst=0, busy=1, s_ready=0.
  - in_mat and flt_mat are frozen.
  - run_cnt increments each cycle. At run_cnt==RUN_CYC-1, go to DONE.
- DONE state (one cycle):
  - res_strobe=1, array_rst=0, busy=1.
  - The next state is LOAD, and array_rst returns to 1.
- Throughput: minimum frame period is 25 accepted beats + RUN_CYC + 1 cycles.
- frame_err clears only on rst.
- rst asserted mid-frame or mid-run: all state returns to reset values immediately. The partial frame is lost and the array is held in reset.
- s_data and s_last are ignored whenever s_valid=0 or s_ready=0.

Optional Feature:
- Macro LOADER_FILTER_REUSE_EN.
- When defined:
  - Adds input port flt_keep (1 bit), sampled with the first beat of each frame (beat_cnt==0).
  - If flt_keep=1, the frame is N_IN beats and flt_mat keeps its previous value.
  - s_last is expected at beat N_IN-1; the framing rules apply with that length.
  - A frame with flt_keep=1 issued before any full filter has loaded uses flt_mat=0.
- When undefined: no flt_keep port, and every frame is N_IN+N_FLT beats.

Decomposition:
- Package conv_loader_pkg holds:
  - state encoding LOAD=2'd0, RUN=2'd1, DONE=2'd2;
  - constants N_IN, N_FLT and FRAME_LEN=25;
  - width of beat_cnt (5) and run_cnt (5).
- One natural sub-module: loader_run_timer, a RUN_CYC down-counter with load and expire outputs.
- The operand register file stays inline.

Test Plan:
- Reset release, then 25 beats 0x01..0x19 with s_last on beat 25:
  - in_mat element 0 = 0x01, element 15 = 0x10; flt_mat element 0 = 0x11, element 8 = 0x19.
  - array_rst falls the cycle after the last beat; res_strobe pulses exactly RUN_CYC cycles after that edge.
- Operand frame (array output check): input all 0x01 and filter all 0x01 through the loader into the array:
  - at res_strobe, all four outputs equal 0x09.
- Early s_last on beat 10:
  - frame_err=1, state stays LOAD, array_rst stays 1.
  - A following correct 25-beat frame runs normally and frame_err stays 1.
- Randomised s_valid gaps (50%) during LOAD, plus s_valid held high during RUN:
  - s_ready=0 throughout RUN, no beats are lost or duplicated, and operands are identical to the gap-free case.
- rst asserted in RUN at run_cnt=7:
  - all outputs return to reset values asynchronously with no res_strobe.
  - The next frame loads from beat 0.
- LOADER_FILTER_REUSE_EN: load a full frame with filter 0x02, then a 16-beat frame with flt_keep=1:
  - flt_mat is unchanged (all 0x02), and res_strobe fires after the second RUN.
